// File: rtl/lookup_table_writer.sv
// Datapath-side writer for an external dual-port table: port 0 carries registered
// datapath writes, port 1 serves host reads/writes with forwarding from port 0.
module lookup_table_writer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                running,
  input  logic                valid,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DATA_W-1:0]   in1,
  input  logic [DATA_W-1:0]   in2,
  output logic [DATA_W-1:0]   out0,
  output logic [ADDR_W-1:0]   ext_dp_addr_0_port_0,
  output logic [DATA_W-1:0]   ext_dp_out_0_port_0,
  input  logic [DATA_W-1:0]   ext_dp_in_0_port_0,
  output logic                ext_dp_enable_0_port_0,
  output logic                ext_dp_write_0_port_0,
  output logic [ADDR_W-1:0]   ext_dp_addr_0_port_1,
  output logic [DATA_W-1:0]   ext_dp_out_0_port_1,
  input  logic [DATA_W-1:0]   ext_dp_in_0_port_1,
  output logic                ext_dp_enable_0_port_1,
  output logic                ext_dp_write_0_port_1
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic                w_sample;
  logic                w_host_wr;
  logic                w_host_rd;
  logic                w_p0_hit;
  logic                w_unused;

  logic [ADDR_W-1:0]   r_p0_addr;
  logic [DATA_W-1:0]   r_p0_data;
  logic                r_p0_we;
  logic [COUNT_W-1:0]  r_count;
  logic [ADDR_W-1:0]   r_p1_addr;
  logic [DATA_W-1:0]   r_p1_data;
  logic                r_p1_we;
  logic                r_p1_rd;
  logic                r_rvalid;
  logic                r_fwd;
  logic [DATA_W-1:0]   r_fwd_data;

  assign w_sample  = running & ~run;
  assign w_host_wr = valid & (|wstrb);
  assign w_host_rd = valid & ~(|wstrb);
  // Port 0 write this cycle targets the same word as port 1.
  assign w_p0_hit  = r_p0_we && (r_p0_addr == r_p1_addr);
  assign w_unused  = ^{ext_dp_in_0_port_0, in0[DATA_W-1:ADDR_W], in2[DATA_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_addr  <= '0;
      r_p0_data  <= '0;
      r_p0_we    <= 1'b0;
      r_count    <= '0;
      r_p1_addr  <= '0;
      r_p1_data  <= '0;
      r_p1_we    <= 1'b0;
      r_p1_rd    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_p0_we <= w_sample & in2[0];
      if (w_sample) begin
        r_p0_addr <= in0[ADDR_W-1:0];
        r_p0_data <= in1;
      end
      if (run) begin
        r_count <= '0;
      end else if (r_p0_we && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
      if (valid) begin
        r_p1_addr <= addr;
      end
      if (w_host_wr) begin
        r_p1_data <= wdata;
      end
      r_p1_we  <= w_host_wr;
      r_p1_rd  <= w_host_rd;
      r_rvalid <= r_p1_rd;
      // Memory returns pre-write data on a same-cycle collision, so capture port 0 data.
      r_fwd    <= r_p1_rd & w_p0_hit;
      if (r_p1_rd) begin
        r_fwd_data <= r_p0_data;
      end
    end
  end

  always_comb begin
    ext_dp_addr_0_port_0   = r_p0_addr;
    ext_dp_out_0_port_0    = r_p0_data;
    ext_dp_write_0_port_0  = r_p0_we;
    ext_dp_enable_0_port_0 = r_p0_we;

    ext_dp_addr_0_port_1   = r_p1_addr;
    ext_dp_out_0_port_1    = r_p1_data;
    ext_dp_write_0_port_1  = r_p1_we & ~w_p0_hit;
    ext_dp_enable_0_port_1 = (r_p1_we & ~w_p0_hit) | r_p1_rd;

    rvalid = r_rvalid;
    rdata  = '0;
    if (r_rvalid) begin
      rdata = r_fwd ? r_fwd_data : ext_dp_in_0_port_1;
    end

    out0              = '0;
    out0[COUNT_W-1:0] = r_count;
  end

endmodule

// File: tb/tb_lookup_table_writer.sv
// Directed bench for lookup_table_writer with a behavioural dual-port RAM and a
// read-data scoreboard; a second instance with a 2-bit counter covers saturation.
module tb_lookup_table_writer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              run, running, valid;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, in0, in1, in2;
  logic              rvalid;
  logic [DATA_W-1:0] rdata, out0;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_out, p1_out, p0_in, p1_in;
  logic              p0_en, p0_we, p1_en, p1_we;

  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata, s_out0;
  logic [ADDR_W-1:0] s_p0_addr, s_p1_addr;
  logic [DATA_W-1:0] s_p0_out, s_p1_out;
  logic              s_p0_en, s_p0_we, s_p1_en, s_p1_we;

  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] shadow [0:255];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lookup_table_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .valid(valid),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .rvalid(rvalid), .rdata(rdata),
    .in0(in0), .in1(in1), .in2(in2), .out0(out0),
    .ext_dp_addr_0_port_0(p0_addr), .ext_dp_out_0_port_0(p0_out),
    .ext_dp_in_0_port_0(p0_in), .ext_dp_enable_0_port_0(p0_en),
    .ext_dp_write_0_port_0(p0_we),
    .ext_dp_addr_0_port_1(p1_addr), .ext_dp_out_0_port_1(p1_out),
    .ext_dp_in_0_port_1(p1_in), .ext_dp_enable_0_port_1(p1_en),
    .ext_dp_write_0_port_1(p1_we)
  );

  lookup_table_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COUNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .run(run), .running(running), .valid(valid),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .rvalid(s_rvalid), .rdata(s_rdata),
    .in0(in0), .in1(in1), .in2(in2), .out0(s_out0),
    .ext_dp_addr_0_port_0(s_p0_addr), .ext_dp_out_0_port_0(s_p0_out),
    .ext_dp_in_0_port_0(p0_in), .ext_dp_enable_0_port_0(s_p0_en),
    .ext_dp_write_0_port_0(s_p0_we),
    .ext_dp_addr_0_port_1(s_p1_addr), .ext_dp_out_0_port_1(s_p1_out),
    .ext_dp_in_0_port_1(p1_in), .ext_dp_enable_0_port_1(s_p1_en),
    .ext_dp_write_0_port_1(s_p1_we)
  );

  assign p0_in = '0;

  // Synchronous dual-port RAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (p0_en && p0_we) mem[p0_addr] <= p0_out;
    if (p1_en && p1_we) mem[p1_addr] <= p1_out;
    if (p1_en) p1_in <= mem[p1_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then service the read scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {63'd0, rvalid}, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        chk("rdata", {32'd0, rdata}, {32'd0, exp_v});
      end
    end
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    valid = 1'b1; wstrb = 4'hF; addr = a; wdata = d;
    shadow[a] = d;
    tick();
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a);
    valid = 1'b1; wstrb = 4'h0; addr = a;
    exp_q.push_back(shadow[a]);
    tick();
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b1; valid = 1'b1; wstrb = 4'h0;
    addr = 8'd3; wdata = 32'hFFFF_FFFF; in0 = 32'd5; in1 = 32'h1234_5678; in2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("rst_out0", {32'd0, out0}, 64'd0);
      chk("rst_p0_we", {62'd0, p0_we, p0_en}, 64'd0);
      chk("rst_p1_en", {62'd0, p1_we, p1_en}, 64'd0);
      chk("rst_p_addr", {48'd0, p0_addr, p1_addr}, 64'd0);
    end
    valid = 1'b0; running = 1'b0; in2 = '0;
    rst = 1'b0;
    tick();
    chk("idle_p1_en", {63'd0, p1_en}, 64'd0);

    // Single datapath write
    running = 1'b1; run = 1'b1;
    tick();
    run = 1'b0; in0 = 32'd5; in1 = 32'hDEAD_BEEF; in2 = 32'd1;
    tick();
    chk("p0_addr", {56'd0, p0_addr}, 64'd5);
    chk("p0_data", {32'd0, p0_out}, 64'hDEAD_BEEF);
    chk("p0_we_en", {62'd0, p0_we, p0_en}, 64'd3);
    chk("out0_t1", {32'd0, out0}, 64'd0);
    shadow[5] = 32'hDEAD_BEEF;
    in2 = '0;
    tick();
    chk("out0_t2", {32'd0, out0}, 64'd1);
    chk("p0_we_off", {63'd0, p0_we}, 64'd0);
    host_read(8'd5);
    chk("read_p1_en", {62'd0, p1_we, p1_en}, 64'd1);
    tick();
    tick();

    // Alternating enables, address wraps to low bits
    run = 1'b1;
    tick();
    run = 1'b0; in0 = 32'h105;
    for (int i = 0; i < 10; i++) begin
      in2 = (i % 2 == 0) ? 32'd1 : 32'd0;
      in1 = i;
      tick();
      chk("alt_p0_we", {63'd0, p0_we}, {63'd0, in2[0]});
      if (in2[0]) chk("alt_p0_addr", {56'd0, p0_addr}, 64'h05);
    end
    shadow[5] = 32'd8;
    in2 = '0; running = 1'b0;
    tick();
    chk("alt_out0", {32'd0, out0}, 64'd5);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_clear_out0", {32'd0, out0}, 64'd0);

    // Pipelined reads
    host_write(8'd1, 32'h11);
    host_write(8'd2, 32'h22);
    host_write(8'd3, 32'h33);
    valid = 1'b1; wstrb = 4'h0;
    addr = 8'd1; exp_q.push_back(shadow[1]); tick();
    addr = 8'd2; exp_q.push_back(shadow[2]); tick();
    chk("pipe_rv1", {63'd0, rvalid}, 64'd1);
    addr = 8'd3; exp_q.push_back(shadow[3]); tick();
    chk("pipe_rv2", {63'd0, rvalid}, 64'd1);
    valid = 1'b0;
    tick();
    chk("pipe_rv3", {63'd0, rvalid}, 64'd1);
    tick();
    chk("pipe_rv_end", {63'd0, rvalid}, 64'd0);

    // Same-address write conflict: datapath wins
    running = 1'b1; in0 = 32'd7; in1 = 32'h5555; in2 = 32'd1;
    valid = 1'b1; wstrb = 4'hF; addr = 8'd7; wdata = 32'hAAAA;
    tick();
    chk("conf_p1_we_en", {62'd0, p1_we, p1_en}, 64'd0);
    chk("conf_p0_we", {63'd0, p0_we}, 64'd1);
    shadow[7] = 32'h5555;
    in2 = '0; running = 1'b0; valid = 1'b0; wstrb = 4'h0;
    tick();
    host_write(8'd8, 32'hBEEF);
    chk("hw_p1_we_en", {62'd0, p1_we, p1_en}, 64'd3);
    chk("hw_p1_addr", {56'd0, p1_addr}, 64'd8);
    chk("hw_p1_out", {32'd0, p1_out}, 64'hBEEF);
    tick();
    chk("hw_no_rvalid", {63'd0, rvalid}, 64'd0);
    host_read(8'd7);
    host_read(8'd8);
    tick();
    tick();

    // Read forwarded from colliding datapath write
    host_write(8'd9, 32'hFFFF);
    tick();
    running = 1'b1; in0 = 32'd9; in1 = 32'h1234; in2 = 32'd1;
    valid = 1'b1; wstrb = 4'h0; addr = 8'd9;
    exp_q.push_back(32'h1234);
    shadow[9] = 32'h1234;
    tick();
    in2 = '0; running = 1'b0; valid = 1'b0;
    tick();
    tick();
    host_read(8'd9);
    tick();
    tick();

    // Counter saturation in the 2-bit instance
    running = 1'b1; run = 1'b1;
    tick();
    run = 1'b0; in0 = 32'd20; in2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      in1 = 32'h100 + i;
      tick();
    end
    in2 = '0; running = 1'b0;
    tick();
    tick();
    chk("sat_out0", {32'd0, s_out0}, 64'd3);
    chk("nosat_out0", {32'd0, out0}, 64'd5);
    tick();
    chk("hold_out0", {32'd0, out0}, 64'd5);

    // Reset with a read in flight
    valid = 1'b1; wstrb = 4'h0; addr = 8'd5;
    tick();
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("mid_rst_out0", {32'd0, out0}, 64'd0);
    chk("mid_rst_p1_en", {63'd0, p1_en}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
